// File: rtl/bitstream_pkg.sv
// Shared types and constants for the stochastic bitstream blocks.
package bitstream_pkg;

    localparam int BITSTREAM_LEN = 4096;

    typedef enum logic {
        IDLE,
        ACCUM
    } dec_state_t;

endpackage

// File: rtl/window_counter.sv
// Up-counter with synchronous clear (priority over enable) and a
// terminal-count flag raised while the count equals TERM.
module window_counter
    import bitstream_pkg::*;
#(
    parameter int               CNT_W = 13,
    parameter logic [CNT_W-1:0] TERM  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_q,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= r_q + CNT_W'(1);
        end
    end

    assign o_q  = r_q;
    assign o_tc = (r_q == TERM);

endmodule

// File: rtl/bitstream_decoder.sv
// Windowed stochastic-to-binary converter: counts ones over WINDOW
// accepted samples and presents the count over valid/ready.
module bitstream_decoder
    import bitstream_pkg::*;
#(
    parameter int WINDOW     = BITSTREAM_LEN,
    parameter int CNT_W      = $clog2(WINDOW + 1),
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             in_en,
    output logic [CNT_W-1:0] count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    dec_state_t       r_state;
    dec_state_t       w_next;
    logic             w_accept;
    logic             w_done;
    logic             w_clr;
    logic             w_n_tc;
    logic             w_acc_tc_unused;
    logic [CNT_W-1:0] w_n;
    logic [CNT_W-1:0] w_acc;
    logic [CNT_W-1:0] w_result;
    logic [CNT_W-1:0] r_count;
    logic             r_valid;
    logic             r_overrun;

    assign w_accept = (r_state == ACCUM) && in_en;
    assign w_done   = w_accept && w_n_tc;
    // A restart and a completion both wipe the running window.
    assign w_clr    = start || w_done;
    assign w_result = w_acc + CNT_W'(bit_in);

    window_counter #(
        .CNT_W (CNT_W),
        .TERM  (CNT_W'(WINDOW - 1))
    ) u_n_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (w_accept),
        .o_q   (w_n),
        .o_tc  (w_n_tc)
    );

    window_counter #(
        .CNT_W (CNT_W),
        .TERM  (CNT_W'(WINDOW))
    ) u_acc_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_clr),
        .i_en  (w_accept && bit_in),
        .o_q   (w_acc),
        .o_tc  (w_acc_tc_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = ACCUM;
                end
            end
            ACCUM: begin
                if (start) begin
                    w_next = ACCUM;
                end else if (w_done && !CONTINUOUS) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (w_done) begin
            r_count <= w_result;
            r_valid <= 1'b1;
            if (r_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign count     = r_count;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;
    assign busy      = (r_state == ACCUM);

    // w_n is only observed through its terminal-count flag.
    logic w_n_unused;
    assign w_n_unused = ^w_n;

endmodule

// File: tb/tb_bitstream_decoder.sv
// Bench for bitstream_decoder: one-shot and continuous instances share
// stimulus; a window-queue model is compared every cycle.
module tb_bitstream_decoder;
    import bitstream_pkg::*;

    localparam int WIN = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       bit_in = 1'b0;
    logic       in_en = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] cnt [2];
    logic       vld [2];
    logic       bsy [2];
    logic       ovr [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bitstream_decoder #(.WINDOW(WIN), .CONTINUOUS(1'b0)) u_one (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in),
        .in_en(in_en), .count(cnt[0]), .out_valid(vld[0]),
        .out_ready(out_ready), .busy(bsy[0]), .overrun(ovr[0])
    );

    bitstream_decoder #(.WINDOW(WIN), .CONTINUOUS(1'b1)) u_cont (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in),
        .in_en(in_en), .count(cnt[1]), .out_valid(vld[1]),
        .out_ready(out_ready), .busy(bsy[1]), .overrun(ovr[1])
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a window is the list of accepted samples; the result is its sum.
    bit m_win [2][$];
    int m_cnt [2];
    bit m_valid [2];
    bit m_ovr [2];
    bit m_act [2];

    task automatic model_step(input int k, input bit cont);
        bit done;
        int res;
        done = 1'b0;
        res  = 0;
        if (m_act[k] && in_en) begin
            m_win[k].push_back(bit_in);
            if (m_win[k].size() == WIN) begin
                done = 1'b1;
                for (int i = 0; i < m_win[k].size(); i++) res += int'(m_win[k][i]);
                m_win[k].delete();
            end
        end
        if (done) begin
            if (m_valid[k] && !out_ready) m_ovr[k] = 1'b1;
            m_valid[k] = 1'b1;
            m_cnt[k]   = res;
        end else if (m_valid[k] && out_ready) begin
            m_valid[k] = 1'b0;
        end
        if (start) begin
            m_act[k] = 1'b1;
            m_win[k].delete();
        end else if (done && !cont) begin
            m_act[k] = 1'b0;
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_win[k].delete();
                m_cnt[k] = 0;
                m_valid[k] = 1'b0;
                m_ovr[k] = 1'b0;
                m_act[k] = 1'b0;
            end
        end else begin
            model_step(0, 1'b0);
            model_step(1, 1'b1);
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_count%0d", k), int'(cnt[k]), m_cnt[k]);
                chk($sformatf("model_valid%0d", k), int'(vld[k]), int'(m_valid[k]));
                chk($sformatf("model_busy%0d", k), int'(bsy[k]), int'(m_act[k]));
                chk($sformatf("model_overrun%0d", k), int'(ovr[k]), int'(m_ovr[k]));
            end
        end
    end

    task automatic step(input bit s, input bit b, input bit e, input bit r);
        @(negedge clk);
        start = s;
        bit_in = b;
        in_en = e;
        out_ready = r;
        @(posedge clk);
        #2;
    endtask

    bit w5 [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
    bit w3 [8] = '{1, 0, 1, 0, 1, 0, 0, 0};

    initial begin
        int a;
        int c;
        bit e;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_count", int'(cnt[k]), 0);
            chk("reset_valid", int'(vld[k]), 0);
            chk("reset_busy", int'(bsy[k]), 0);
            chk("reset_overrun", int'(ovr[k]), 0);
        end
        rst = 1'b0;

        // All ones, one-shot: result appears after the 8th accepted sample.
        step(1, 0, 0, 0);
        chk("t1_busy", int'(bsy[0]), 1);
        repeat (7) step(0, 1, 1, 0);
        chk("t1_pre_valid", int'(vld[0]), 0);
        step(0, 1, 1, 0);
        chk("t1_valid", int'(vld[0]), 1);
        chk("t1_count", int'(cnt[0]), 8);
        chk("t1_busy_after", int'(bsy[0]), 0);
        chk("t1_cont_busy", int'(bsy[1]), 1);
        step(0, 0, 0, 1);
        chk("t1_consumed", int'(vld[0]), 0);
        chk("t1_hold", int'(cnt[0]), 8);

        // Alternating bits with in_en low every third cycle.
        step(1, 0, 0, 0);
        a = 0;
        c = 0;
        while (a < 8) begin
            e = (c % 3) != 2;
            step(0, (a % 2) == 0, e, 0);
            if (e) a++;
            c++;
            if (a == 7) chk("t2_pre_valid", int'(vld[0]), 0);
        end
        chk("t2_count", int'(cnt[0]), 4);
        chk("t2_valid", int'(vld[0]), 1);
        step(0, 0, 0, 1);

        // Continuous, unconsumed results across two windows.
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, w5[i], 1, 0);
        chk("t3_count1", int'(cnt[1]), 5);
        chk("t3_overrun1", int'(ovr[1]), 0);
        for (int i = 0; i < 8; i++) step(0, w3[i], 1, 0);
        chk("t3_count2", int'(cnt[1]), 3);
        chk("t3_overrun2", int'(ovr[1]), 1);
        chk("t3_oneshot_idle", int'(cnt[0]), 5);

        // Restart after five samples discards the partial window.
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        repeat (5) step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        repeat (3) step(0, 1, 1, 0);
        chk("t5_no_early0", int'(vld[0]), 0);
        chk("t5_no_early1", int'(vld[1]), 0);
        repeat (5) step(0, 1, 1, 0);
        chk("t5_count0", int'(cnt[0]), 8);
        chk("t5_count1", int'(cnt[1]), 8);
        chk("t5_valid0", int'(vld[0]), 1);

        // Asynchronous reset mid-window.
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);
        repeat (3) step(0, 1, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t6_count", int'(cnt[k]), 0);
            chk("t6_valid", int'(vld[k]), 0);
            chk("t6_busy", int'(bsy[k]), 0);
            chk("t6_overrun", int'(ovr[k]), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (8) step(0, 1, 1, 1);
        chk("t6_idle_valid", int'(vld[1]), 0);
        chk("t6_idle_busy", int'(bsy[1]), 0);

        // Completion coincides with consumption: no overrun.
        step(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, w5[i], 1, 0);
        chk("t4_count1", int'(cnt[1]), 5);
        for (int i = 0; i < 7; i++) step(0, w3[i], 1, 0);
        step(0, w3[7], 1, 1);
        chk("t4_valid", int'(vld[1]), 1);
        chk("t4_count2", int'(cnt[1]), 3);
        chk("t4_overrun", int'(ovr[1]), 0);
        step(0, 0, 0, 1);
        chk("t4_consumed", int'(vld[1]), 0);
        step(0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
